zorro3_autoconfig_host: RTL and testbench
=========================================

Name: zorro3_autoconfig_host

Overview:
Host-side Zorro III AutoConfig initiator: the counterpart to the card's autoconfig responder. It drives the card's CFGIN_n and runs config-space bus cycles to read the 18 ROM nibbles (type, size, product, flags, manufacturer, serial). It then either writes a base-address nibble or issues shutup, and checks that the card's CFGOUT_n falls. It sits in the bring-up/host FPGA and on the card-verification bench.

Parameters:
FC_SETUP, 2, cycles FC/ADDRL/READ held valid before FCS_n falls (covers the card's 2-flop FC synchroniser); range 1..7
ACCESS_CYCLES, 3, cycles FCS_n/DS_n held low; DIN sampled on the last one; range 2..15
CFGOUT_TIMEOUT, 16, cycles to wait for card CFGOUT_n low after the final write

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a configuration pass when idle
base_nibble  in  4  base-address nibble written at register 0x22
force_shutup  in  1  sampled at start; 1 = always shut card up
CFGIN_n  out  1  to card CFGIN_n; low while a pass is active
CFGOUT_n  in  1  from card CFGOUT_n
FCS_n  out  1  full cycle strobe
DS_n  out  1  data strobe
READ  out  1  1 = read, 0 = write
FC  out  3  function code; 3'b101 during cycles, 3'b000 otherwise
ADDRL  out  7  config address: ADDRL[5:0]=idx[6:1], ADDRL[6]=idx[0]
DOUT  out  4  write data nibble
DIN  in  4  read data nibble from card
busy  out  1  pass in progress
done  out  1  one-cycle pulse at end of pass
ok  out  1  valid from done: Z3 card configured and CFGOUT_n seen low
err  out  1  valid from done: CFGOUT_n timeout
er_type  out  8  {idx00,idx01} true nibbles
prod_id  out  8  de-inverted idx02,03
er_flags  out  8  de-inverted idx04,05
mfg_id  out  16  de-inverted idx08..0B
serial  out  32  de-inverted idx0C..13

Behaviour:
- Reset (any time, including mid-cycle): CFGIN_n=1, FCS_n=1, DS_n=1, READ=1, FC=0, ADDRL=0, DOUT=0, busy=0, done=0, ok=0, err=0, all captured registers 0; FSM to IDLE.
- FSM states: IDLE, ADDR, STROBE, RECOVER, DECIDE, WRITE_ADDR, WRITE_STROBE, WRITE_RECOVER, WAIT_CFG, FINISH.
- IDLE: on start, set busy=1 and CFGIN_n=0, latch force_shutup and base_nibble, clear ok/err, set seq=0. start while busy is ignored.
- Read sequence indices, in order: 00,01,02,03,04,05,08,09,0A,0B,0C,0D,0E,0F,10,11,12,13.
- ADDR: drive ADDRL from the index, READ=1, FC=101, FCS_n=1 for FC_SETUP cycles.
- STROBE: FCS_n=0, DS_n=0 for ACCESS_CYCLES cycles. DIN is registered on the final cycle into the field slot. Idx 00/01 are stored as-is; all others are stored as ~DIN.
- RECOVER: FCS_n=1, DS_n=1 for 1 cycle; this is the card's FCS_n rising edge. Then advance seq; after idx 13, go to DECIDE.
- DECIDE: write=base when !force_shutup and er_type[7:6]==2'b10; otherwise write=shutup.
- Base write: register index 0x22 (ADDRL=7'h11), DOUT=base_nibble.
- Shutup write: index 0x26 (ADDRL=7'h13), DOUT=0.
- Write cycle timing matches a read, with READ=0. DOUT is valid from WRITE_ADDR through WRITE_RECOVER.
- WAIT_CFG: count up to CFGOUT_TIMEOUT.
  - CFGOUT_n==0 → FINISH with ok = (write was base), err=0.
  - Timeout → FINISH with ok=0, err=1.
- FINISH: done=1 for exactly 1 cycle, busy=0, CFGIN_n=1, FC=0; return to IDLE. Captured fields hold until the next start or reset.
- Pass length (no timeout): 19×(FC_SETUP+ACCESS_CYCLES+1) + WAIT_CFG cycles + 2.

Decomposition:
- Package zorro3_ac_pkg:
  - FSM state enum
  - read-index table (18 entries)
  - constants IDX_BASE=7'h22, IDX_SHUTUP=7'h26, FC_DATA=3'b101
  - function idx_to_addrl(idx) → {idx[0], idx[6:1]}
- Sub-module zorro3_cfg_cycle: single bus-cycle engine.
  - Inputs: go, rd, idx, wdata.
  - Outputs: strobes, rdata, cyc_done.
  - Owns the ADDR/STROBE/RECOVER timing; top-level FSM sequences it.

Test Plan:
- Responder model with mfg 0x07DB, prod 0x72, serial 421, type 0xA/size 0x4; start, base_nibble=4'h4 → er_type=8'hA4, prod_id=8'h72, mfg_id=16'h07DB, serial=32'h000001A5, model addr_match=4'h4, CFGOUT_n low, done pulse, ok=1, err=0.
- Same card, force_shutup=1 → write at ADDRL=7'h13 only, model configured=0, CFGOUT_n low, ok=0, err=0.
- Empty slot (DIN tied 4'hF, CFGOUT_n stuck 1) → er_type=8'hFF, shutup issued, err=1 after CFGOUT_TIMEOUT cycles, ok=0.
- Check FC=101 for ≥FC_SETUP cycles before each FCS_n fall; FCS_n low exactly ACCESS_CYCLES; 19 FCS_n rising edges per pass.
- Assert RESET during STROBE of idx 0C → all outputs at reset values same cycle; later start gives a clean full pass.
- start pulses at seq 5 and during WAIT_CFG → ignored; exactly one done per pass.

Source files
------------

// File: rtl/zorro3_ac_pkg.sv
// Shared types and constants for the Zorro III AutoConfig host.
// Includes the FSM states, the ROM read order and the config-space addressing helpers.
package zorro3_ac_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_STROBE,
        S_RECOVER,
        S_DECIDE,
        S_WRITE_ADDR,
        S_WRITE_STROBE,
        S_WRITE_RECOVER,
        S_WAIT_CFG,
        S_FINISH
    } ac_state_t;

    typedef enum logic [1:0] {
        CYC_IDLE,
        CYC_ADDR,
        CYC_STROBE,
        CYC_RECOVER
    } cyc_phase_t;

    localparam int         NUM_READS  = 18;
    localparam logic [6:0] IDX_BASE   = 7'h22;
    localparam logic [6:0] IDX_SHUTUP = 7'h26;
    localparam logic [2:0] FC_DATA    = 3'b101;
    localparam logic [2:0] FC_NONE    = 3'b000;

    // ROM nibble order: 00..05, then 06/07 are skipped, then 08..13.
    function automatic logic [6:0] read_idx(input logic [4:0] seq);
        logic [6:0] idx;
        case (seq)
            5'd0:    idx = 7'h00;
            5'd1:    idx = 7'h01;
            5'd2:    idx = 7'h02;
            5'd3:    idx = 7'h03;
            5'd4:    idx = 7'h04;
            5'd5:    idx = 7'h05;
            5'd6:    idx = 7'h08;
            5'd7:    idx = 7'h09;
            5'd8:    idx = 7'h0A;
            5'd9:    idx = 7'h0B;
            5'd10:   idx = 7'h0C;
            5'd11:   idx = 7'h0D;
            5'd12:   idx = 7'h0E;
            5'd13:   idx = 7'h0F;
            5'd14:   idx = 7'h10;
            5'd15:   idx = 7'h11;
            5'd16:   idx = 7'h12;
            5'd17:   idx = 7'h13;
            default: idx = 7'h00;
        endcase
        return idx;
    endfunction

    function automatic logic [6:0] idx_to_addrl(input logic [6:0] idx);
        return {idx[0], idx[6:1]};
    endfunction

endpackage

// File: rtl/zorro3_cfg_cycle.sv
// Single config-space bus cycle: FC/address setup, FCS_n/DS_n strobe, one recovery cycle.
// A go during RECOVER chains straight into the next cycle with no idle gap.
module zorro3_cfg_cycle
    import zorro3_ac_pkg::*;
#(
    parameter int FC_SETUP      = 2,
    parameter int ACCESS_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       rd,
    input  logic [6:0] idx,
    input  logic [3:0] wdata,
    input  logic [3:0] din,
    output logic       fcs_n,
    output logic       ds_n,
    output logic       read,
    output logic [2:0] fc,
    output logic [6:0] addrl,
    output logic [3:0] dout,
    output logic [3:0] rdata,
    output logic       setup_end,
    output logic       access_end,
    output logic       cyc_done
);

    localparam logic [3:0] SETUP_LAST  = 4'(FC_SETUP - 1);
    localparam logic [3:0] ACCESS_LAST = 4'(ACCESS_CYCLES - 1);

    cyc_phase_t phase, phase_next;
    logic [3:0] cnt, cnt_next;
    logic       rd_q;
    logic [6:0] idx_q;
    logic [3:0] wdata_q;
    logic       active;
    logic       accept;

    assign setup_end  = (phase == CYC_ADDR) && (cnt == SETUP_LAST);
    assign access_end = (phase == CYC_STROBE) && (cnt == ACCESS_LAST);
    assign cyc_done   = (phase == CYC_RECOVER);
    assign accept     = go && ((phase == CYC_IDLE) || (phase == CYC_RECOVER));

    always_comb begin
        phase_next = phase;
        cnt_next   = cnt;
        case (phase)
            CYC_IDLE: begin
                if (go) begin
                    phase_next = CYC_ADDR;
                    cnt_next   = 4'd0;
                end
            end
            CYC_ADDR: begin
                if (setup_end) begin
                    phase_next = CYC_STROBE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            CYC_STROBE: begin
                if (access_end) begin
                    phase_next = CYC_RECOVER;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            CYC_RECOVER: begin
                phase_next = go ? CYC_ADDR : CYC_IDLE;
                cnt_next   = 4'd0;
            end
            default: begin
                phase_next = CYC_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= CYC_IDLE;
            cnt     <= 4'd0;
            rd_q    <= 1'b1;
            idx_q   <= 7'h00;
            wdata_q <= 4'h0;
            rdata   <= 4'h0;
        end else begin
            phase <= phase_next;
            cnt   <= cnt_next;
            if (accept) begin
                rd_q    <= rd;
                idx_q   <= idx;
                wdata_q <= wdata;
            end
            if (access_end) begin
                rdata <= din;
            end
        end
    end

    always_comb begin
        active = (phase != CYC_IDLE);
        fcs_n  = (phase != CYC_STROBE);
        ds_n   = (phase != CYC_STROBE);
        read   = active ? rd_q : 1'b1;
        fc     = active ? FC_DATA : FC_NONE;
        addrl  = active ? idx_to_addrl(idx_q) : 7'h00;
        dout   = (active && !rd_q) ? wdata_q : 4'h0;
    end

endmodule

// File: rtl/zorro3_autoconfig_host.sv
// Host-side Zorro III AutoConfig initiator: reads the 18 ROM nibbles of the card on CFGIN_n,
// then writes its base nibble or shuts it up, and waits for the card's CFGOUT_n to fall.
module zorro3_autoconfig_host
    import zorro3_ac_pkg::*;
#(
    parameter int FC_SETUP       = 2,
    parameter int ACCESS_CYCLES  = 3,
    parameter int CFGOUT_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [3:0]  base_nibble,
    input  logic        force_shutup,
    output logic        CFGIN_n,
    input  logic        CFGOUT_n,
    output logic        FCS_n,
    output logic        DS_n,
    output logic        READ,
    output logic [2:0]  FC,
    output logic [6:0]  ADDRL,
    output logic [3:0]  DOUT,
    input  logic [3:0]  DIN,
    output logic        busy,
    output logic        done,
    output logic        ok,
    output logic        err,
    output logic [7:0]  er_type,
    output logic [7:0]  prod_id,
    output logic [7:0]  er_flags,
    output logic [15:0] mfg_id,
    output logic [31:0] serial
);

    localparam int          TW        = $clog2(CFGOUT_TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(CFGOUT_TIMEOUT - 1);
    localparam logic [4:0]  LAST_SEQ  = 5'(NUM_READS - 1);

    ac_state_t     state, state_next;
    logic [4:0]    seq;
    logic          shutup_q;
    logic [3:0]    base_q;
    logic          write_base;
    logic [TW-1:0] wait_cnt;

    logic          go;
    logic          cyc_rd;
    logic [6:0]    cyc_idx;
    logic [3:0]    cyc_wdata;
    logic [3:0]    rdata;
    logic          setup_end;
    logic          access_end;
    logic          cyc_done;
    logic          choose_base;
    logic [3:0]    nib;

    // Only a genuine Z3 board (er_type[7:6] == 2'b10) gets a base address.
    assign choose_base = !shutup_q && (er_type[7:6] == 2'b10);
    assign nib         = (seq < 5'd2) ? rdata : ~rdata;

    zorro3_cfg_cycle #(
        .FC_SETUP      (FC_SETUP),
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) u_cycle (
        .clk        (CLK),
        .rst        (RESET),
        .go         (go),
        .rd         (cyc_rd),
        .idx        (cyc_idx),
        .wdata      (cyc_wdata),
        .din        (DIN),
        .fcs_n      (FCS_n),
        .ds_n       (DS_n),
        .read       (READ),
        .fc         (FC),
        .addrl      (ADDRL),
        .dout       (DOUT),
        .rdata      (rdata),
        .setup_end  (setup_end),
        .access_end (access_end),
        .cyc_done   (cyc_done)
    );

    always_comb begin
        state_next = state;
        go         = 1'b0;
        cyc_rd     = 1'b1;
        cyc_idx    = read_idx(5'd0);
        cyc_wdata  = 4'h0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_ADDR;
                    go         = 1'b1;
                end
            end
            S_ADDR:   if (setup_end)  state_next = S_STROBE;
            S_STROBE: if (access_end) state_next = S_RECOVER;
            S_RECOVER: begin
                if (seq == LAST_SEQ) begin
                    state_next = S_DECIDE;
                end else begin
                    state_next = S_ADDR;
                    go         = 1'b1;
                    cyc_idx    = read_idx(seq + 5'd1);
                end
            end
            S_DECIDE: begin
                state_next = S_WRITE_ADDR;
                go         = 1'b1;
                cyc_rd     = 1'b0;
                cyc_idx    = choose_base ? IDX_BASE : IDX_SHUTUP;
                cyc_wdata  = choose_base ? base_q : 4'h0;
            end
            S_WRITE_ADDR:    if (setup_end)  state_next = S_WRITE_STROBE;
            S_WRITE_STROBE:  if (access_end) state_next = S_WRITE_RECOVER;
            S_WRITE_RECOVER: state_next = S_WAIT_CFG;
            S_WAIT_CFG: begin
                if (!CFGOUT_n || (wait_cnt == WAIT_LAST)) state_next = S_FINISH;
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            seq        <= 5'd0;
            shutup_q   <= 1'b0;
            base_q     <= 4'h0;
            write_base <= 1'b0;
            wait_cnt   <= '0;
            ok         <= 1'b0;
            err        <= 1'b0;
            er_type    <= 8'h00;
            prod_id    <= 8'h00;
            er_flags   <= 8'h00;
            mfg_id     <= 16'h0000;
            serial     <= 32'h0000_0000;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        seq      <= 5'd0;
                        shutup_q <= force_shutup;
                        base_q   <= base_nibble;
                        ok       <= 1'b0;
                        err      <= 1'b0;
                        er_type  <= 8'h00;
                        prod_id  <= 8'h00;
                        er_flags <= 8'h00;
                        mfg_id   <= 16'h0000;
                        serial   <= 32'h0000_0000;
                    end
                end
                S_RECOVER: begin
                    // Fields fill MSB nibble first, so a left shift lands each nibble in place.
                    if (cyc_done) begin
                        if (seq < 5'd2)       er_type  <= {er_type[3:0], nib};
                        else if (seq < 5'd4)  prod_id  <= {prod_id[3:0], nib};
                        else if (seq < 5'd6)  er_flags <= {er_flags[3:0], nib};
                        else if (seq < 5'd10) mfg_id   <= {mfg_id[11:0], nib};
                        else                  serial   <= {serial[27:0], nib};
                    end
                    if (seq != LAST_SEQ) seq <= seq + 5'd1;
                end
                S_DECIDE:        write_base <= choose_base;
                S_WRITE_RECOVER: wait_cnt   <= '0;
                S_WAIT_CFG: begin
                    if (!CFGOUT_n) begin
                        ok  <= write_base;
                        err <= 1'b0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        ok  <= 1'b0;
                        err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy    = (state != S_IDLE) && (state != S_FINISH);
        done    = (state == S_FINISH);
        CFGIN_n = !busy;
    end

endmodule

// File: tb/tb_zorro3_autoconfig_host.sv
// Directed bench for the AutoConfig host: a card responder model, a bus-timing monitor
// and hand-computed expectations for configure, shutup, empty slot, mid-pass reset and ignored starts.
module tb_zorro3_autoconfig_host;

    localparam int FC_SETUP       = 2;
    localparam int ACCESS_CYCLES  = 3;
    localparam int CFGOUT_TIMEOUT = 16;
    localparam int CYC_LEN        = FC_SETUP + ACCESS_CYCLES + 1;
    localparam int PASS_FAST      = 19 * CYC_LEN + 1 + 1 + 1;
    localparam int PASS_TIMEOUT   = 19 * CYC_LEN + 1 + CFGOUT_TIMEOUT + 1;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start;
    logic        start_main = 1'b0;
    logic        start_extra = 1'b0;
    logic [3:0]  base_nibble = 4'h0;
    logic        force_shutup = 1'b0;
    logic        CFGIN_n;
    logic        CFGOUT_n;
    logic        FCS_n;
    logic        DS_n;
    logic        READ;
    logic [2:0]  FC;
    logic [6:0]  ADDRL;
    logic [3:0]  DOUT;
    logic [3:0]  DIN;
    logic        busy;
    logic        done;
    logic        ok;
    logic        err;
    logic [7:0]  er_type;
    logic [7:0]  prod_id;
    logic [7:0]  er_flags;
    logic [15:0] mfg_id;
    logic [31:0] serial;

    int checks = 0;
    int failures = 0;

    logic       empty_slot = 1'b0;
    int         inject_mode = 0;
    logic       card_cfgout = 1'b1;
    logic       configured = 1'b0;
    logic [3:0] addr_match = 4'h0;
    logic [3:0] shutup_dout = 4'hF;
    int         base_writes = 0;
    int         shutup_writes = 0;
    int         rises = 0;
    int         setup_viol = 0;
    int         low_viol = 0;
    int         done_count = 0;
    int         injected = 0;
    int         wait_countdown = 0;
    logic       prev_fcs = 1'b1;
    logic       prev_cfgin = 1'b1;
    logic [6:0] prev_addrl = 7'h00;
    int         fc_run = 0;
    int         low_run = 0;

    always #5 CLK = ~CLK;

    assign start    = start_main | start_extra;
    assign CFGOUT_n = card_cfgout;

    zorro3_autoconfig_host #(
        .FC_SETUP       (FC_SETUP),
        .ACCESS_CYCLES  (ACCESS_CYCLES),
        .CFGOUT_TIMEOUT (CFGOUT_TIMEOUT)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .start        (start),
        .base_nibble  (base_nibble),
        .force_shutup (force_shutup),
        .CFGIN_n      (CFGIN_n),
        .CFGOUT_n     (CFGOUT_n),
        .FCS_n        (FCS_n),
        .DS_n         (DS_n),
        .READ         (READ),
        .FC           (FC),
        .ADDRL        (ADDRL),
        .DOUT         (DOUT),
        .DIN          (DIN),
        .busy         (busy),
        .done         (done),
        .ok           (ok),
        .err          (err),
        .er_type      (er_type),
        .prod_id      (prod_id),
        .er_flags     (er_flags),
        .mfg_id       (mfg_id),
        .serial       (serial)
    );

    // Card ROM: type A/size 4, prod 0x72, flags 0x30, mfg 0x07DB, serial 421 (0x1A5).
    function automatic logic [3:0] card_nibble(input logic [6:0] idx);
        logic [3:0] t;
        t = 4'h0;
        case (idx)
            7'h00: t = 4'hA;
            7'h01: t = 4'h4;
            7'h02: t = 4'h7;
            7'h03: t = 4'h2;
            7'h04: t = 4'h3;
            7'h09: t = 4'h7;
            7'h0A: t = 4'hD;
            7'h0B: t = 4'hB;
            7'h11: t = 4'h1;
            7'h12: t = 4'hA;
            7'h13: t = 4'h5;
            default: t = 4'h0;
        endcase
        if (idx == 7'h00 || idx == 7'h01) return t;
        return ~t;
    endfunction

    assign DIN = (!empty_slot && !CFGIN_n && READ && FC == 3'b101)
                 ? card_nibble({ADDRL[5:0], ADDRL[6]}) : 4'hF;

    // Responder, bus-timing monitor and start injector, all evaluated on the falling edge.
    always @(negedge CLK) begin
        start_extra = 1'b0;
        if (RESET) begin
            prev_fcs   = 1'b1;
            prev_cfgin = 1'b1;
            prev_addrl = 7'h00;
            fc_run     = 0;
            low_run    = 0;
        end else begin
            if (prev_cfgin && !CFGIN_n) begin
                rises = 0; setup_viol = 0; low_viol = 0; done_count = 0;
                base_writes = 0; shutup_writes = 0; injected = 0; wait_countdown = 0;
                configured = 1'b0; addr_match = 4'h0; shutup_dout = 4'hF; card_cfgout = 1'b1;
            end
            if (prev_fcs && !FCS_n) begin
                if (fc_run < FC_SETUP) setup_viol++;
                low_run = 1;
            end else if (!FCS_n) begin
                low_run++;
            end
            if (wait_countdown > 0) begin
                wait_countdown--;
                if (wait_countdown == 0) begin
                    start_extra = 1'b1;
                    injected++;
                end
            end
            if (!prev_fcs && FCS_n) begin
                rises++;
                if (low_run != ACCESS_CYCLES) low_viol++;
                if (FC == 3'b101 && !READ) begin
                    if (ADDRL == 7'h11) begin
                        base_writes++;
                        addr_match = DOUT;
                        configured = 1'b1;
                        if (!empty_slot) card_cfgout = 1'b0;
                    end else if (ADDRL == 7'h13) begin
                        shutup_writes++;
                        shutup_dout = DOUT;
                        if (!empty_slot) card_cfgout = 1'b0;
                    end
                    if (inject_mode == 2) wait_countdown = 2;
                end
            end
            if (inject_mode == 1 && injected == 0 && ADDRL == 7'h42 && !FCS_n && FC == 3'b101) begin
                start_extra = 1'b1;
                injected++;
            end
            if (FC == 3'b101 && FCS_n) fc_run = (ADDRL == prev_addrl) ? fc_run + 1 : 1;
            else if (FCS_n)            fc_run = 0;
            if (done) done_count++;
            prev_fcs   = FCS_n;
            prev_cfgin = CFGIN_n;
            prev_addrl = ADDRL;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fs, input logic [3:0] base, output int cycles);
        @(negedge CLK);
        force_shutup = fs;
        base_nibble  = base;
        start_main   = 1'b1;
        @(negedge CLK);
        start_main   = 1'b0;
        force_shutup = ~fs;
        base_nibble  = ~base;
        cycles = 1;
        while (!done && cycles < 500) begin
            @(negedge CLK);
            cycles++;
        end
        checkOutput("done_seen", done, 1'b1);
        repeat (3) @(negedge CLK);
    endtask

    task automatic checkTiming(input string tag);
        checkOutput({tag, "_rises"}, rises, 19);
        checkOutput({tag, "_setup_viol"}, setup_viol, 0);
        checkOutput({tag, "_low_viol"}, low_viol, 0);
        checkOutput({tag, "_done_count"}, done_count, 1);
    endtask

    task automatic checkCardFields(input string tag);
        checkOutput({tag, "_er_type"}, er_type, 8'hA4);
        checkOutput({tag, "_prod_id"}, prod_id, 8'h72);
        checkOutput({tag, "_er_flags"}, er_flags, 8'h30);
        checkOutput({tag, "_mfg_id"}, mfg_id, 16'h07DB);
        checkOutput({tag, "_serial"}, serial, 32'h0000_01A5);
    endtask

    initial begin
        #100_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cycles;
        int n;

        repeat (3) @(negedge CLK);
        checkOutput("reset_outputs",
                    {CFGIN_n, FCS_n, DS_n, READ, FC, ADDRL, DOUT, busy, done, ok, err},
                    {1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 7'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        checkOutput("reset_fields", {er_type, prod_id, er_flags, mfg_id}, 40'h0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        $display("[TB] pass 1: configure card with base 4");
        applyStimulus(1'b0, 4'h4, cycles);
        checkCardFields("cfg");
        checkOutput("cfg_addr_match", addr_match, 4'h4);
        checkOutput("cfg_base_writes", base_writes, 1);
        checkOutput("cfg_shutup_writes", shutup_writes, 0);
        checkOutput("cfg_configured", configured, 1'b1);
        checkOutput("cfg_cfgout", CFGOUT_n, 1'b0);
        checkOutput("cfg_ok_err", {ok, err}, 2'b10);
        checkOutput("cfg_cycles", cycles, PASS_FAST);
        checkOutput("cfg_idle", {busy, CFGIN_n}, 2'b01);
        checkTiming("cfg");

        $display("[TB] pass 2: forced shutup");
        applyStimulus(1'b1, 4'h9, cycles);
        checkOutput("shut_shutup_writes", shutup_writes, 1);
        checkOutput("shut_base_writes", base_writes, 0);
        checkOutput("shut_dout", shutup_dout, 4'h0);
        checkOutput("shut_configured", configured, 1'b0);
        checkOutput("shut_cfgout", CFGOUT_n, 1'b0);
        checkOutput("shut_ok_err", {ok, err}, 2'b00);
        checkOutput("shut_er_type", er_type, 8'hA4);
        checkOutput("shut_cycles", cycles, PASS_FAST);
        checkTiming("shut");

        $display("[TB] pass 3: empty slot, start pulsed during WAIT_CFG");
        empty_slot  = 1'b1;
        inject_mode = 2;
        applyStimulus(1'b0, 4'h4, cycles);
        checkOutput("empty_er_type", er_type, 8'hFF);
        checkOutput("empty_prod_mfg", {prod_id, mfg_id}, 24'h0);
        checkOutput("empty_serial", serial, 32'h0);
        checkOutput("empty_shutup_writes", shutup_writes, 1);
        checkOutput("empty_base_writes", base_writes, 0);
        checkOutput("empty_ok_err", {ok, err}, 2'b01);
        checkOutput("empty_cycles", cycles, PASS_TIMEOUT);
        checkOutput("empty_injected", injected, 1);
        checkOutput("empty_busy_after", busy, 1'b0);
        checkTiming("empty");
        empty_slot  = 1'b0;

        $display("[TB] pass 4: start pulsed at seq 5");
        inject_mode = 1;
        applyStimulus(1'b0, 4'hC, cycles);
        checkOutput("seq5_injected", injected, 1);
        checkOutput("seq5_addr_match", addr_match, 4'hC);
        checkOutput("seq5_ok_err", {ok, err}, 2'b10);
        checkOutput("seq5_cycles", cycles, PASS_FAST);
        checkOutput("seq5_busy_after", busy, 1'b0);
        checkTiming("seq5");
        inject_mode = 0;

        $display("[TB] pass 5: reset during strobe of idx 0C");
        @(negedge CLK);
        base_nibble = 4'h4;
        start_main  = 1'b1;
        @(negedge CLK);
        start_main  = 1'b0;
        n = 0;
        while (!(ADDRL == 7'h06 && !FCS_n) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("reach_idx0c", n < 500, 1'b1);
        checkOutput("pre_reset_mfg", mfg_id, 16'h07DB);
        RESET = 1'b1;
        #1;
        checkOutput("midreset_outputs",
                    {CFGIN_n, FCS_n, DS_n, READ, FC, ADDRL, DOUT, busy, done, ok, err},
                    {1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 7'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        checkOutput("midreset_fields", {er_type, prod_id, er_flags, mfg_id}, 40'h0);
        checkOutput("midreset_serial", serial, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        applyStimulus(1'b0, 4'h4, cycles);
        checkCardFields("post");
        checkOutput("post_addr_match", addr_match, 4'h4);
        checkOutput("post_ok_err", {ok, err}, 2'b10);
        checkOutput("post_cycles", cycles, PASS_FAST);
        checkTiming("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
